// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if
//   Register bus between spi_req_arbiter (master) and spi_top (slave).
//   Addr   : register address (0 ctrl/status, 1 TxData, 2 RxData, 3 SS)
//   Wr     : one-cycle write strobe
//   DataWr : write data, 8'hFF when not writing
//   DataRd : registered read data from spi_top
interface spi_req_arbiter_if;
  logic [1:0] Addr;
  logic       Wr;
  logic [7:0] DataWr;
  logic [7:0] DataRd;

  modport master (output Addr, Wr, DataWr, input DataRd);
  modport slave  (input Addr, Wr, DataWr, output DataRd);
endinterface

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter
//   Shares one spi_top between two requesters. Per transaction: round-robin
//   grant, program slave select / TX byte / control, poll EndTx (with
//   timeout), read RX byte, deselect, pulse Done to the served requester.
// Ports:
//   Clk, Rst_n    clock, asynchronous active-low reset
//   Req[1:0]      request levels, held until Done
//   Slv0/Slv1     target slave index per requester
//   Tx0/Tx1       byte to send per requester
//   Gnt[1:0]      one-hot, requester currently served
//   Done[1:0]     one-cycle completion pulse to the served requester
//   Err           valid with Done, 1 = poll timeout
//   RxByte        received byte, updated at Done (unchanged on timeout)
//   bus           register bus to spi_top (master modport)
module spi_req_arbiter #(
  parameter logic [7:0]  CFG0    = 8'h04,
  parameter logic [7:0]  CFG1    = 8'h08,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] Req,
  input  logic [2:0] Slv0,
  input  logic [2:0] Slv1,
  input  logic [7:0] Tx0,
  input  logic [7:0] Tx1,
  output logic [1:0] Gnt,
  output logic [1:0] Done,
  output logic       Err,
  output logic [7:0] RxByte,
  spi_req_arbiter_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SEL   = 4'd1,
    S_LDTX  = 4'd2,
    S_CFG   = 4'd3,
    S_START = 4'd4,
    S_POLL  = 4'd5,
    S_RDRX  = 4'd6,
    S_DESEL = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;       // round-robin pointer
  logic       sel_q, sel_d;       // requester being served
  logic [2:0] slv_q, slv_d;
  logic [7:0] tx_q, tx_d;
  logic [9:0] cnt_q, cnt_d;       // poll timeout / RDRX cycle counter
  logic       tout_q, tout_d;
  logic [7:0] rxd_q, rxd_d;       // RX byte captured in RDRX

  logic [1:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic [7:0] dwr_q, dwr_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] rxbyte_q, rxbyte_d;

  logic [7:0] cfg;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    slv_d   = slv_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    rxd_d   = rxd_q;

    unique case (state_q)
      S_IDLE: begin
        if (|Req) begin
          // pointer wins; fall back to the other requester if it is idle
          sel_d   = Req[ptr_q] ? ptr_q : ~ptr_q;
          slv_d   = sel_d ? Slv1 : Slv0;
          tx_d    = sel_d ? Tx1 : Tx0;
          tout_d  = 1'b0;
          state_d = S_SEL;
        end
      end
      S_SEL:   state_d = S_LDTX;
      S_LDTX:  state_d = S_CFG;
      S_CFG:   state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        cnt_d = cnt_q + 10'd1;
        // first POLL cycle ignored: DataRd still reflects the previous Addr
        if (cnt_q != '0 && bus.DataRd[7]) begin
          cnt_d   = '0;
          state_d = S_RDRX;
        end else if (cnt_q == 10'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = S_DESEL;
        end
      end
      S_RDRX: begin
        if (cnt_q == '0) begin
          cnt_d = 10'd1;
        end else begin
          rxd_d   = bus.DataRd;
          state_d = S_DESEL;
        end
      end
      S_DESEL: state_d = S_DONE;
      S_DONE: begin
        ptr_d   = ~sel_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next state so they align with it
    cfg      = sel_d ? CFG1 : CFG0;
    wr_d     = 1'b0;
    addr_d   = 2'd0;
    dwr_d    = 8'hFF;
    done_d   = '0;
    err_d    = 1'b0;
    rxbyte_d = rxbyte_q;
    gnt_d    = (state_d == S_IDLE) ? 2'b00 : (sel_d ? 2'b10 : 2'b01);

    unique case (state_d)
      S_SEL: begin
        wr_d   = 1'b1;
        addr_d = 2'd3;
        dwr_d  = ~(8'h01 << slv_d);
      end
      S_LDTX: begin
        wr_d   = 1'b1;
        addr_d = 2'd1;
        dwr_d  = tx_d;
      end
      S_CFG: begin
        wr_d   = 1'b1;
        dwr_d  = cfg & 8'hBF;
      end
      S_START: begin
        wr_d   = 1'b1;
        dwr_d  = cfg | 8'h40;
      end
      S_RDRX:  addr_d = 2'd2;
      S_DESEL: begin
        wr_d   = 1'b1;
        addr_d = 2'd3;
        dwr_d  = 8'hFF;
      end
      S_DONE: begin
        done_d = sel_d ? 2'b10 : 2'b01;
        err_d  = tout_d;
        if (!tout_d) rxbyte_d = rxd_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      sel_q    <= 1'b0;
      slv_q    <= '0;
      tx_q     <= '0;
      cnt_q    <= '0;
      tout_q   <= 1'b0;
      rxd_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      dwr_q    <= '1;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rxbyte_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      slv_q    <= slv_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
      rxd_q    <= rxd_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      dwr_q    <= dwr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rxbyte_q <= rxbyte_d;
    end
  end

  assign bus.Addr   = addr_q;
  assign bus.Wr     = wr_q;
  assign bus.DataWr = dwr_q;
  assign Gnt        = gnt_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign RxByte     = rxbyte_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter
//   Scoreboard bench: each transaction pushes its expected register-bus
//   writes and its expected Done/Err/RxByte; a negedge monitor pops and
//   compares as the DUT produces them. spi_top is a small behavioural model.
module tb_spi_req_arbiter;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [1:0] Req;
  logic [2:0] Slv0, Slv1;
  logic [7:0] Tx0, Tx1;
  logic [1:0] Gnt, Done;
  logic       Err;
  logic [7:0] RxByte;

  spi_req_arbiter_if bus ();

  spi_req_arbiter #(
    .CFG0    (8'h04),
    .CFG1    (8'h08),
    .TIMEOUT (1023)
  ) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Req    (Req),
    .Slv0   (Slv0),
    .Slv1   (Slv1),
    .Tx0    (Tx0),
    .Tx1    (Tx1),
    .Gnt    (Gnt),
    .Done   (Done),
    .Err    (Err),
    .RxByte (RxByte),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;
  int d0_cnt = 0;
  int d1_cnt = 0;

  logic [9:0]  exp_wr[$];
  logic [10:0] exp_done[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // spi_top model: EndTx rises m_delay cycles after the StartTx write
  // (m_delay 0 = never); DataRd is a registered read of the addressed reg.
  int unsigned m_delay;
  logic [7:0]  m_rx;
  logic [15:0] m_cnt;
  logic        m_endtx;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_cnt      <= '0;
      m_endtx    <= 1'b0;
      bus.DataRd <= '0;
    end else begin
      if (bus.Wr && bus.Addr == 2'd0 && bus.DataWr[6]) begin
        m_cnt   <= 16'(m_delay);
        m_endtx <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 16'd1;
        if (m_cnt == 16'd1) m_endtx <= 1'b1;
      end
      case (bus.Addr)
        2'd0:    bus.DataRd <= {m_endtx, 7'h00};
        2'd2:    bus.DataRd <= m_rx;
        default: bus.DataRd <= 8'h00;
      endcase
    end
  end

  // scoreboard monitor
  logic [9:0]  mon_ew;
  logic [10:0] mon_ed;

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (bus.Wr) begin
        if (exp_wr.size() == 0) check("wr_extra", {1'b1, bus.Addr, bus.DataWr}, 0);
        else begin
          mon_ew = exp_wr.pop_front();
          check("wr", {bus.Addr, bus.DataWr}, mon_ew);
        end
      end else begin
        check("dwr_idle", bus.DataWr, 8'hFF);
      end
      if (Done != 2'b00) begin
        if (Done[0]) d0_cnt++;
        if (Done[1]) d1_cnt++;
        if (exp_done.size() == 0) check("done_extra", {Done, Err, RxByte}, 0);
        else begin
          mon_ed = exp_done.pop_front();
          check("done", {Done, Err, RxByte}, mon_ed);
        end
      end
    end
  end

  task automatic push_txn(input int unsigned r, input logic [2:0] slv, input logic [7:0] tx,
                          input logic err, input logic [7:0] rx);
    logic [7:0] ss;
    ss      = 8'hFF;
    ss[slv] = 1'b0;
    exp_wr.push_back({2'd3, ss});
    exp_wr.push_back({2'd1, tx});
    exp_wr.push_back({2'd0, (r == 0) ? 8'h04 : 8'h08});
    exp_wr.push_back({2'd0, (r == 0) ? 8'h44 : 8'h48});
    exp_wr.push_back({2'd3, 8'hFF});
    exp_done.push_back({(r == 0) ? 2'b01 : 2'b10, err, rx});
  endtask

  // counts posedges from the current negedge until Done is seen
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (Done == 2'b00 && n < 3000);
    if (Done == 2'b00) check("done_wait", 32'(Done), 32'h1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"}, bus.Addr, 2'd0);
    check({tag, "_wr"}, bus.Wr, 1'b0);
    check({tag, "_dwr"}, bus.DataWr, 8'hFF);
    check({tag, "_gnt"}, Gnt, 2'b00);
    check({tag, "_done"}, Done, 2'b00);
    check({tag, "_err"}, Err, 1'b0);
    check({tag, "_rx"}, RxByte, 8'h00);
  endtask

  int         n;
  int         d0_before;
  logic [1:0] gseq[4];

  initial begin
    Rst_n = 1'b0; Req = 2'b00;
    Slv0 = '0; Slv1 = '0; Tx0 = '0; Tx1 = '0;
    m_delay = 20; m_rx = 8'h3C;
    repeat (3) @(negedge Clk);
    check_reset_state("rst");
    Rst_n = 1'b1;
    @(negedge Clk);

    // single transaction, requester 0
    Slv0 = 3'd3; Tx0 = 8'hA5;
    push_txn(0, 3'd3, 8'hA5, 1'b0, 8'h3C);
    Req = 2'b01;
    wait_done(n);
    Req = 2'b00;
    check("t1_latency", n, 30);
    repeat (5) @(negedge Clk);
    check("t1_rx_hold", RxByte, 8'h3C);

    // reset restores pointer to 0; simultaneous requests alternate
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    Slv0 = 3'd1; Tx0 = 8'h11; Slv1 = 3'd6; Tx1 = 8'h22;
    m_delay = 7; m_rx = 8'h5A;
    for (int i = 0; i < 4; i++) push_txn(i % 2, (i % 2 == 0) ? 3'd1 : 3'd6,
                                        (i % 2 == 0) ? 8'h11 : 8'h22, 1'b0, 8'h5A);
    Req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      gseq[i] = Gnt;
      if (i == 3) Req = 2'b00;
    end
    check("t2_gnt0", gseq[0], 2'b01);
    check("t2_gnt1", gseq[1], 2'b10);
    check("t2_gnt2", gseq[2], 2'b01);
    check("t2_gnt3", gseq[3], 2'b10);
    repeat (3) @(negedge Clk);

    // timeout on requester 1 (pointer at 0 but requester 0 idle)
    Slv1 = 3'd0; Tx1 = 8'h3E;
    m_delay = 0; m_rx = 8'hC7;
    push_txn(1, 3'd0, 8'h3E, 1'b1, 8'h5A);
    Req = 2'b10;
    wait_done(n);
    Req = 2'b00;
    check("t3_latency", n, 1029);
    check("t3_err", Err, 1'b1);
    @(negedge Clk);
    check("t3_err_clr", Err, 1'b0);
    check("t3_rx_hold", RxByte, 8'h5A);
    repeat (3) @(negedge Clk);

    // asynchronous reset during POLL
    Slv0 = 3'd2; Tx0 = 8'h77;
    m_delay = 20; m_rx = 8'h99;
    push_txn(0, 3'd2, 8'h77, 1'b0, 8'h99);
    Req = 2'b01;
    repeat (10) @(negedge Clk);
    #3 Rst_n = 1'b0;
    #1;
    check_reset_state("t4_async");
    check("t4_pending_wr", exp_wr.size(), 1);
    exp_wr.delete();
    exp_done.delete();
    Req = 2'b00;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check_reset_state("t4_rel");
    Slv0 = 3'd5; Tx0 = 8'hC3;
    m_delay = 3; m_rx = 8'hE1;
    push_txn(0, 3'd5, 8'hC3, 1'b0, 8'hE1);
    Req = 2'b01;
    wait_done(n);
    Req = 2'b00;
    check("t4_latency", n, 13);
    repeat (3) @(negedge Clk);

    // Req and inputs dropped/changed after grant
    Slv0 = 3'd0; Tx0 = 8'h0F;
    m_delay = 5; m_rx = 8'h96;
    push_txn(0, 3'd0, 8'h0F, 1'b0, 8'h96);
    d0_before = d0_cnt;
    Req = 2'b01;
    @(negedge Clk);
    check("t5_gnt", Gnt, 2'b01);
    @(negedge Clk);
    Req = 2'b00; Slv0 = 3'd7; Tx0 = 8'hFF;
    wait_done(n);
    repeat (30) @(negedge Clk);
    check("t5_done0_pulses", d0_cnt - d0_before, 1);
    check("t5_gnt_clr", Gnt, 2'b00);

    check("wr_left", exp_wr.size(), 0);
    check("done_left", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
